// File: rtl/ccff_chain_loader_if.sv
// Host-side bitstream interface for ccff_chain_loader: start request, word
// handshake (din/din_valid/din_ready) and sequence status (busy/done/error).
interface ccff_chain_loader_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              busy;
    logic              done;
    logic              error;

    // Host side: issues start and words, observes status
    modport master (
        output start, din, din_valid,
        input  din_ready, busy, done, error
    );

    // Loader side
    modport slave (
        input  start, din, din_valid,
        output din_ready, busy, done, error
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes DATA_W-bit bitstream words from a host and shifts
// exactly CHAIN_LEN bits, MSB first, into a configuration flop chain.
// Optional feature macro CCFF_PARITY_CHECK_EN: after loading, recirculate the
// chain once (tail fed back to head) and compare the parity of the bits driven
// against the parity of the bits read back; a mismatch sets the sticky error.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 12,
    parameter int DATA_W    = 8
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    ccff_chain_loader_if.slave   host,
    output logic                 ccff_head,
    output logic                 ccff_shift_en,
    input  logic                 ccff_tail
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(DATA_W - 1);
    localparam logic [WB_W-1:0]  WB_ONE   = WB_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
`ifdef CCFF_PARITY_CHECK_EN
    localparam logic [2:0] S_VERIFY = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  bit_cnt;   // chain bits shifted so far (verify cycles in VERIFY)
    logic [WB_W-1:0]   word_bit;  // bits consumed from the current word
    logic [DATA_W-1:0] shreg;
    logic              shift_last;

    // A word ends when it is exhausted or the chain is full; the leftover
    // low bits of a final partial word are simply dropped.
    assign shift_last = (word_bit == WB_LAST) || (bit_cnt == CNT_LAST);

`ifdef CCFF_PARITY_CHECK_EN
    logic par_drv;
    logic par_tail;
    logic error_q;

    // Sequencer with readback parity verification
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            word_bit <= '0;
            shreg    <= '0;
            par_drv  <= 1'b0;
            par_tail <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.start) begin
                        state    <= S_LOAD;
                        bit_cnt  <= '0;
                        par_drv  <= 1'b0;
                        par_tail <= 1'b0;
                        error_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (host.din_valid) begin
                        shreg    <= host.din;
                        word_bit <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg    <= shreg << 1;
                    bit_cnt  <= bit_cnt + CNT_ONE;
                    word_bit <= word_bit + WB_ONE;
                    par_drv  <= par_drv ^ shreg[DATA_W-1];
                    if (shift_last) begin
                        if (bit_cnt == CNT_LAST) begin
                            // Reuse the bit counter to time the recirculation pass
                            state    <= S_VERIFY;
                            bit_cnt  <= '0;
                            par_tail <= 1'b0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_VERIFY: begin
                    bit_cnt  <= bit_cnt + CNT_ONE;
                    par_tail <= par_tail ^ ccff_tail;
                    if (bit_cnt == CNT_LAST) begin
                        state <= S_DONE;
                        // Fold in the final tail bit so error lines up with done
                        if (par_drv != (par_tail ^ ccff_tail)) begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign host.error = error_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;

    // Sequencer: load words, shift them out, pulse done
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            word_bit <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.start) begin
                        state   <= S_LOAD;
                        bit_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (host.din_valid) begin
                        shreg    <= host.din;
                        word_bit <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg    <= shreg << 1;
                    bit_cnt  <= bit_cnt + CNT_ONE;
                    word_bit <= word_bit + WB_ONE;
                    if (shift_last) begin
                        state <= (bit_cnt == CNT_LAST) ? S_DONE : S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign host.error = 1'b0;
`endif

    logic din_ready_c;

    // Chain-side drive and host handshake decoded from the current state
    always_comb begin
        din_ready_c   = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        case (state)
            S_LOAD: begin
                din_ready_c = 1'b1;
            end
            S_SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = shreg[DATA_W-1];
            end
`ifdef CCFF_PARITY_CHECK_EN
            S_VERIFY: begin
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
            end
`endif
            default: begin
                din_ready_c = 1'b0;
            end
        endcase
    end

    assign host.din_ready = din_ready_c;
    assign host.busy      = (state != S_IDLE);
    assign host.done      = (state == S_DONE);
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (12-bit and 5-bit chains) with
// behavioural chain models; expected head bits are queued as words are driven
// and popped as the loader shifts. Honours CCFF_PARITY_CHECK_EN if defined.
module tb_ccff_chain_loader;
    logic clk = 1'b0;
    logic prog_reset = 1'b1;

    always #5 clk = ~clk;

    ccff_chain_loader_if #(.DATA_W(8)) hif12 ();
    ccff_chain_loader_if #(.DATA_W(8)) hif5  ();

    logic head12, sen12, tail12;
    logic head5, sen5, tail5;
    logic [11:0] chain12 = '0;
    logic [4:0]  chain5  = '0;
    logic        stuck12 = 1'b0;

    ccff_chain_loader #(.CHAIN_LEN(12), .DATA_W(8)) u_dut12 (
        .prog_clk(clk), .prog_reset(prog_reset), .host(hif12),
        .ccff_head(head12), .ccff_shift_en(sen12), .ccff_tail(tail12)
    );

    ccff_chain_loader #(.CHAIN_LEN(5), .DATA_W(8)) u_dut5 (
        .prog_clk(clk), .prog_reset(prog_reset), .host(hif5),
        .ccff_head(head5), .ccff_shift_en(sen5), .ccff_tail(tail5)
    );

    int errs = 0;
    int checks = 0;

    logic q12[$];
    logic q5[$];
    int pushed12 = 0;
    int pushed5 = 0;
    int rdy12 = 0, se12 = 0, busy12 = 0, done12 = 0;
    int rdy5 = 0, se5 = 0, busy5 = 0, done5 = 0;

`ifdef CCFF_PARITY_CHECK_EN
    localparam int VERIFY12 = 12;
    localparam int VERIFY5  = 5;
`else
    localparam int VERIFY12 = 0;
    localparam int VERIFY5  = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Chain models; bit 5 of the 12-bit chain can be forced stuck at 0
    assign tail12 = chain12[11];
    assign tail5  = chain5[4];

    always @(posedge clk) begin : chain_model
        logic [11:0] nx;
        if (sen12) begin
            nx = {chain12[10:0], head12};
            if (stuck12) nx[5] = 1'b0;
            chain12 <= nx;
        end
        if (sen5) chain5 <= {chain5[3:0], head5};
    end

    // Monitors: scoreboard pop on every shift cycle, activity counters
    always @(negedge clk) begin
        if (hif12.din_ready) rdy12++;
        if (hif12.busy)      busy12++;
        if (hif12.done)      done12++;
        if (sen12) begin
            se12++;
            if (q12.size() > 0) chk("head12", head12, q12.pop_front());
`ifdef CCFF_PARITY_CHECK_EN
            else chk("recirc12", head12, tail12);
`else
            else chk("extra_shift12", sen12, 1'b0);
`endif
        end else begin
            chk("head_off12", head12, 1'b0);
        end

        if (hif5.din_ready) rdy5++;
        if (hif5.busy)      busy5++;
        if (hif5.done)      done5++;
        if (sen5) begin
            se5++;
            if (q5.size() > 0) chk("head5", head5, q5.pop_front());
`ifdef CCFF_PARITY_CHECK_EN
            else chk("recirc5", head5, tail5);
`else
            else chk("extra_shift5", sen5, 1'b0);
`endif
        end else begin
            chk("head_off5", head5, 1'b0);
        end
    end

    task automatic send12(input logic [7:0] w, input int stall);
        int n = 0;
        while (!hif12.din_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("ready_timeout12", hif12.din_ready, 1'b1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_se12", sen12, 1'b0);
            @(negedge clk);
        end
        hif12.din = w;
        hif12.din_valid = 1'b1;
        for (int b = 7; b >= 0; b--) begin
            if (pushed12 < 12) begin q12.push_back(w[b]); pushed12++; end
        end
        @(negedge clk);
        hif12.din_valid = 1'b0;
    endtask

    task automatic send5(input logic [7:0] w);
        int n = 0;
        while (!hif5.din_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("ready_timeout5", hif5.din_ready, 1'b1);
        hif5.din = w;
        hif5.din_valid = 1'b1;
        for (int b = 7; b >= 0; b--) begin
            if (pushed5 < 5) begin q5.push_back(w[b]); pushed5++; end
        end
        @(negedge clk);
        hif5.din_valid = 1'b0;
    endtask

    task automatic run12(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                         input logic exp_err, input logic chk_chain);
        int n = 0;
        logic [11:0] exp_chain;
        exp_chain = {w0, w1[7:4]};
        rdy12 = 0; se12 = 0; busy12 = 0; done12 = 0; pushed12 = 0;
        @(negedge clk);
        hif12.start = 1'b1;
        @(negedge clk);
        hif12.start = 1'b0;
        chk("err_clr12", hif12.error, 1'b0);
        chk("busy_on12", hif12.busy, 1'b1);
        send12(w0, 0);
        send12(w1, stall);
        while (!hif12.done && n < 200) begin @(negedge clk); n++; end
        chk("done_seen12", hif12.done, 1'b1);
        chk("err12", hif12.error, exp_err);
        @(negedge clk);
        #1;
        chk("done_pulse12", hif12.done, 1'b0);
        chk("idle12", hif12.busy, 1'b0);
        chk("rdy_cycles12", rdy12, 2 + stall);
        chk("se_cycles12", se12, 12 + VERIFY12);
        chk("busy_cycles12", busy12, 2 + 12 + 1 + stall + VERIFY12);
        chk("done_count12", done12, 1);
        chk("q_empty12", q12.size(), 0);
        if (chk_chain) chk("chain12", chain12, exp_chain);
    endtask

    initial begin
        hif12.start = 1'b0; hif12.din = '0; hif12.din_valid = 1'b0;
        hif5.start  = 1'b0; hif5.din  = '0; hif5.din_valid  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy12", hif12.busy, 1'b0);
        chk("rst_ready12", hif12.din_ready, 1'b0);
        chk("rst_done12", hif12.done, 1'b0);
        chk("rst_err12", hif12.error, 1'b0);
        chk("rst_se12", sen12, 1'b0);
        chk("rst_busy5", hif5.busy, 1'b0);
        chk("rst_se5", sen5, 1'b0);
        prog_reset = 1'b0;

        // Two words, no stalls: chain ends up 1010_0101_0011
        run12(8'hA5, 8'h3C, 0, 1'b0, 1'b1);
        chk("chain_seq12", chain12, 12'b1010_0101_0011);

        // Host stalls 5 cycles before the second word
        chain12 = '0;
        run12(8'hA5, 8'h3C, 5, 1'b0, 1'b1);

        // Reset on the 4th SHIFT cycle aborts the load
        q12.delete(); pushed12 = 0;
        @(negedge clk);
        hif12.start = 1'b1;
        @(negedge clk);
        hif12.start = 1'b0;
        send12(8'hFF, 0);
        repeat (3) @(negedge clk);
        chk("se_pre_rst12", sen12, 1'b1);
        prog_reset = 1'b1;
        @(negedge clk);
        chk("abort_se12", sen12, 1'b0);
        chk("abort_busy12", hif12.busy, 1'b0);
        chk("abort_ready12", hif12.din_ready, 1'b0);
        chk("abort_done12", hif12.done, 1'b0);
        chk("abort_head12", head12, 1'b0);
        prog_reset = 1'b0;
        q12.delete(); pushed12 = 0;
        run12(8'h5A, 8'hC3, 0, 1'b0, 1'b1);

`ifdef CCFF_PARITY_CHECK_EN
        // Fault-free verify preserves contents; then stuck-at-0 on chain bit 5.
        // 0xA7 has odd parity and a 1 at chain bit 5; the stuck flop zeroes
        // everything that passes through it, so readback parity is even.
        run12(8'h96, 8'hE0, 0, 1'b0, 1'b1);
        stuck12 = 1'b1;
        run12(8'hA7, 8'h00, 0, 1'b1, 1'b0);
        stuck12 = 1'b0;
        run12(8'hA5, 8'h3C, 0, 1'b0, 1'b1);
`endif

        // 5-bit chain: single word, top 5 bits used, extra start ignored
        begin
            int n = 0;
            rdy5 = 0; se5 = 0; busy5 = 0; done5 = 0; pushed5 = 0;
            @(negedge clk);
            hif5.start = 1'b1;
            @(negedge clk);
            hif5.start = 1'b0;
            send5(8'hB7);
            chk("busy_mid5", hif5.busy, 1'b1);
            hif5.start = 1'b1;
            @(negedge clk);
            hif5.start = 1'b0;
            while (!hif5.done && n < 200) begin @(negedge clk); n++; end
            chk("done_seen5", hif5.done, 1'b1);
            chk("err5", hif5.error, 1'b0);
            @(negedge clk);
            #1;
            chk("rdy_cycles5", rdy5, 1);
            chk("se_cycles5", se5, 5 + VERIFY5);
            chk("busy_cycles5", busy5, 1 + 5 + 1 + VERIFY5);
            chk("done_count5", done5, 1);
            chk("q_empty5", q5.size(), 0);
            chk("chain5", chain5, 5'b10110);
            repeat (3) @(negedge clk);
            chk("stay_idle5", hif5.busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
